// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    // 2'd3 is unused and steers back to ST_IDLE on the next edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor. The ovf signal exists
// only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub_if
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             d_bit, bout_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (bin_q),
        .d_o    (d_bit),
        .bout_o (bout_bit)
    );

    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    // NOTE: datapath registers are reset too, because diff/borrow must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // NOTE: every next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sub_if.in_valid) begin
                    a_sh_d  = sub_if.a;
                    b_sh_d  = sub_if.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // a_sh doubles as the result register: difference bits enter at the MSB.
                a_sh_d = {d_bit, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                bin_d  = bout_bit;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = a_sh_d;
                    borrow_d = bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit a_sh_q[0]/b_sh_q[0] are the loaded operand MSBs.
                    ovf_d    = (a_sh_q[0] != b_sh_q[0]) && (d_bit != a_sh_q[0]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (sub_if.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sub_if.in_ready  = (state_q == ST_IDLE);
    assign sub_if.out_valid = (state_q == ST_DONE);
    assign sub_if.diff      = diff_q;
    assign sub_if.borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign sub_if.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the directed
// cases and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(8)) m8 ();
    serial_subtractor_if #(.WIDTH(4)) m4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .sub_if(m8));
    serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .sub_if(m4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the accepting edge until out_valid is seen, capped at 40.
    task automatic wait8(output int lat);
        lat = 0;
        while (m8.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        m8.a        = a;
        m8.b        = b;
        m8.in_valid = 1'b1;
        tick();
        m8.in_valid = 1'b0;
        wait8(lat);
    endtask

    task automatic release8();
        m8.out_ready = 1'b1;
        tick();
        m8.out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        int         lat_bad;
        logic [3:0] a4;
        logic [3:0] b4;
        logic [4:0] exp5;

        m8.in_valid  = 1'b0;
        m8.a         = '0;
        m8.b         = '0;
        m8.out_ready = 1'b0;
        m4.in_valid  = 1'b0;
        m4.a         = '0;
        m4.b         = '0;
        m4.out_ready = 1'b1;
        lat_bad      = 0;

        // Reset state
        #2;
        check("rst_in_ready", m8.in_ready, 1'b1);
        check("rst_out_valid", m8.out_valid, 1'b0);
        check("rst_diff", m8.diff, 8'h00);
        check("rst_borrow", m8.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", m8.ovf, 1'b0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: 0x05 - 0x03; out_valid 8 edges after the accepting edge (9 counting it)
        run8(8'h05, 8'h03, lat);
        check("t1_latency", lat, 8);
        check("t1_diff", m8.diff, 8'h02);
        check("t1_borrow", m8.borrow, 1'b0);
        check("t1_in_ready_done", m8.in_ready, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("t1_ovf", m8.ovf, 1'b0);
`endif
        release8();
        check("t1_idle_out_valid", m8.out_valid, 1'b0);
        check("t1_idle_in_ready", m8.in_ready, 1'b1);
        check("t1_idle_diff_hold", m8.diff, 8'h02);

        // 2: borrow and signed-overflow cases
        run8(8'h03, 8'h05, lat);
        check("t2a_diff", m8.diff, 8'hFE);
        check("t2a_borrow", m8.borrow, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2a_ovf", m8.ovf, 1'b0);
`endif
        release8();
        run8(8'h80, 8'h01, lat);
        check("t2b_diff", m8.diff, 8'h7F);
        check("t2b_borrow", m8.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("t2b_ovf", m8.ovf, 1'b1);
`endif
        release8();
        run8(8'h00, 8'h80, lat);
        check("t2c_diff", m8.diff, 8'h80);
        check("t2c_borrow", m8.borrow, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2c_ovf", m8.ovf, 1'b1);
`endif
        release8();
        run8(8'h01, 8'hFF, lat);
        check("t2d_diff", m8.diff, 8'h02);
        check("t2d_borrow", m8.borrow, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2d_ovf", m8.ovf, 1'b0);
`endif
        release8();

        // 3: result held in DONE while out_ready stays low
        run8(8'h5A, 8'h3C, lat);
        check("t3_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_out_valid", m8.out_valid, 1'b1);
            check("t3_hold_in_ready", m8.in_ready, 1'b0);
            check("t3_hold_diff", m8.diff, 8'h1E);
            check("t3_hold_borrow", m8.borrow, 1'b0);
        end
        release8();
        check("t3_released_out_valid", m8.out_valid, 1'b0);
        check("t3_released_in_ready", m8.in_ready, 1'b1);

        // 6: in_valid held high with changing operands; only the accept-edge pair counts
        m8.a        = 8'h10;
        m8.b        = 8'h01;
        m8.in_valid = 1'b1;
        tick();
        lat = 0;
        while (m8.out_valid !== 1'b1 && lat < 40) begin
            m8.a = m8.a + 8'h11;
            m8.b = m8.b + 8'h07;
            tick();
            lat++;
        end
        check("t6_latency", lat, 8);
        check("t6_diff", m8.diff, 8'h0F);
        check("t6_borrow", m8.borrow, 1'b0);
        // out_ready and in_valid together in DONE: back to IDLE, no accept yet
        m8.a         = 8'h20;
        m8.b         = 8'h30;
        m8.out_ready = 1'b1;
        tick();
        m8.out_ready = 1'b0;
        check("t6_no_overlap_out_valid", m8.out_valid, 1'b0);
        check("t6_no_overlap_in_ready", m8.in_ready, 1'b1);
        tick();
        m8.in_valid = 1'b0;
        check("t6_second_accept", m8.in_ready, 1'b0);
        wait8(lat);
        check("t6b_latency", lat, 8);
        check("t6b_diff", m8.diff, 8'hF0);
        check("t6b_borrow", m8.borrow, 1'b1);
        release8();

        // 4: asynchronous reset three edges into RUN
        m8.a        = 8'h12;
        m8.b        = 8'h34;
        m8.in_valid = 1'b1;
        tick();
        m8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check("t4_rst_out_valid", m8.out_valid, 1'b0);
        check("t4_rst_diff", m8.diff, 8'h00);
        check("t4_rst_borrow", m8.borrow, 1'b0);
        check("t4_rst_in_ready", m8.in_ready, 1'b1);
        rst = 1'b0;
        tick();
        run8(8'hFF, 8'hFF, lat);
        check("t4_after_latency", lat, 8);
        check("t4_after_diff", m8.diff, 8'h00);
        check("t4_after_borrow", m8.borrow, 1'b0);
        release8();

        // 5: WIDTH=4 exhaustive, out_ready held high
        check("t5_in_ready", m4.in_ready, 1'b1);
        for (int i = 0; i < 256; i++) begin
            a4          = 4'(i >> 4);
            b4          = 4'(i);
            exp5        = {1'b0, a4} - {1'b0, b4};
            m4.a        = a4;
            m4.b        = b4;
            m4.in_valid = 1'b1;
            tick();
            m4.in_valid = 1'b0;
            lat = 0;
            while (m4.out_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            if (lat != 4) lat_bad++;
            check("t5_result", {m4.borrow, m4.diff}, exp5);
            tick();
        end
        check("t5_latency_bad_count", lat_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
